// File: rtl/riscv_dmem_misalign_pkg.sv
// Shared types for the data-side misaligned-access handler: bus size/protection
// encodings, the misalignment-mode constants and the split FSM state encoding.
package riscv_dmem_misalign_pkg;

  typedef enum logic [1:0] {
    BIU_BYTE  = 2'd0,
    BIU_HWORD = 2'd1,
    BIU_WORD  = 2'd2,
    BIU_DWORD = 2'd3
  } biu_size_t;

  typedef logic [2:0] biu_prot_t;

  localparam int MISALIGN_TRAP  = 0;
  localparam int MISALIGN_SPLIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_RESP  = 2'd2
  } misalign_state_t;

endpackage

// File: rtl/riscv_dmem_misalign_detect.sv
// Combinational misalignment flag: the address is not a multiple of the access size.
module riscv_dmem_misalign_detect
  import riscv_dmem_misalign_pkg::*;
(
  input  logic [2:0] adr_lsb_i,
  input  biu_size_t  size_i,
  output logic       misaligned_o
);

  // NOTE: every path assigns misaligned_o, so no latch is inferred.
  always_comb begin
    case (size_i)
      BIU_BYTE:  misaligned_o = 1'b0;
      BIU_HWORD: misaligned_o = adr_lsb_i[0];
      BIU_WORD:  misaligned_o = |adr_lsb_i[1:0];
      default:   misaligned_o = |adr_lsb_i;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_misalign.sv
// Data-side misaligned-access handler: aligned requests pass straight through,
// misaligned ones either trap or are split into byte accesses merged into one response.
module riscv_dmem_misalign
  import riscv_dmem_misalign_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MODE = MISALIGN_SPLIT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [XLEN-1:0] adr_i,
  input  biu_size_t       size_i,
  input  logic            lock_i,
  input  biu_prot_t       prot_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            misaligned_o,
  output logic            stall_o,
  output logic            req_o,
  output logic [XLEN-1:0] adr_o,
  output biu_size_t       size_o,
  output logic            lock_o,
  output biu_prot_t       prot_o,
  output logic            we_o,
  output logic [XLEN-1:0] d_o,
  input  logic [XLEN-1:0] q_i,
  input  logic            ack_i,
  input  logic            err_i
);

  localparam int BPW = XLEN / 8;
  localparam int LW  = $clog2(BPW);
  localparam int CW  = LW + 1;

  misalign_state_t r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_last;
  logic [XLEN-1:0] r_base;
  logic [XLEN-1:0] r_d;
  logic [XLEN-1:0] r_merge;
  biu_prot_t       r_prot;
  logic            r_we;
  logic            r_trap;
  logic            r_err;

  logic            w_mis;
  logic            w_idle;
  logic            w_up;
  logic            w_pass;
  logic            w_trap;
  logic            w_split;
  logic [CW-1:0]   w_last;
  logic [XLEN-1:0] w_byte_adr;
  logic [LW-1:0]   w_lane;

  riscv_dmem_misalign_detect u_detect (
    .adr_lsb_i    (adr_i[2:0]),
    .size_i       (size_i),
    .misaligned_o (w_mis)
  );

  // A trap or split-error pulse is answering the still-held request; it must not be resampled.
  assign w_idle  = (r_state == ST_IDLE);
  assign w_up    = w_idle && req_i && !r_trap && !r_err;
  assign w_pass  = w_up && !w_mis;
  assign w_trap  = w_up && w_mis && ((MODE == MISALIGN_TRAP) || lock_i);
  assign w_split = w_up && w_mis && (MODE != MISALIGN_TRAP) && !lock_i;

  assign w_byte_adr = r_base + XLEN'(r_cnt);
  assign w_lane     = w_byte_adr[LW-1:0];

  always_comb begin
    case (size_i)
      BIU_BYTE:  w_last = CW'(0);
      BIU_HWORD: w_last = CW'(1);
      BIU_WORD:  w_last = CW'(3);
      default:   w_last = CW'(7);
    endcase
  end

  // NOTE: the capture registers are only read in SPLIT/RESP, which reset never enters, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (w_split) begin
      r_base <= adr_i;
      r_last <= w_last;
      r_we   <= we_i;
      r_prot <= prot_i;
      r_d    <= d_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_merge <= '0;
      r_trap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_trap <= w_trap;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_split) begin
            r_cnt   <= '0;
            r_merge <= '0;
            r_state <= ST_SPLIT;
          end
        end
        ST_SPLIT: begin
          if (err_i) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (ack_i) begin
            r_merge[w_lane*8 +: 8] <= q_i[w_lane*8 +: 8];
            r_cnt                  <= r_cnt + CW'(1);
            if (r_cnt == r_last) r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_o        = w_pass;
    adr_o        = adr_i;
    size_o       = size_i;
    lock_o       = lock_i;
    prot_o       = prot_i;
    we_o         = we_i;
    d_o          = d_i;
    q_o          = q_i;
    ack_o        = w_pass && ack_i;
    err_o        = (w_pass && err_i) || r_trap || r_err;
    misaligned_o = r_trap;
    case (r_state)
      ST_SPLIT: begin
        req_o  = 1'b1;
        adr_o  = w_byte_adr;
        size_o = BIU_BYTE;
        lock_o = 1'b0;
        prot_o = r_prot;
        we_o   = r_we;
        d_o    = r_d;
        ack_o  = 1'b0;
        err_o  = 1'b0;
      end
      ST_RESP: begin
        req_o = 1'b0;
        q_o   = r_merge;
        ack_o = 1'b1;
        err_o = 1'b0;
      end
      default: ;
    endcase
    stall_o = !w_idle || (req_i && !ack_o && !err_o);
  end

endmodule

// File: tb/tb_riscv_dmem_misalign.sv
// Scoreboard bench for riscv_dmem_misalign: a split-mode and a trap-mode instance share
// one upstream driver, one byte-addressed memory responder and one response monitor.
`timescale 1ns/1ps
module tb_riscv_dmem_misalign;
  import riscv_dmem_misalign_pkg::*;

  typedef struct {
    logic        err;
    logic        mis;
    logic        chk_q;
    logic [31:0] q;
    logic [31:0] qmask;
    int          lat;
    int          cnt;
    logic        stall;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        up_req  = 1'b0;
  logic        up_lock = 1'b0;
  logic        up_we   = 1'b0;
  logic [31:0] up_adr  = '0;
  logic [31:0] up_d    = '0;
  biu_size_t   up_size = BIU_BYTE;
  biu_prot_t   up_prot = '0;
  logic        sel_trap = 1'b0;

  logic [31:0] dn_q   = '0;
  logic        dn_ack = 1'b0;
  logic        dn_err = 1'b0;

  logic [31:0] s_q, t_q, s_adr, t_adr, s_d, t_d;
  logic        s_ack, t_ack, s_err, t_err, s_mis, t_mis, s_stall, t_stall;
  logic        s_req, t_req, s_lock, t_lock, s_we, t_we;
  biu_size_t   s_size, t_size;
  biu_prot_t   s_prot, t_prot;

  riscv_dmem_misalign #(.XLEN(32), .MODE(MISALIGN_SPLIT)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .req_i(up_req & ~sel_trap), .adr_i(up_adr), .size_i(up_size),
    .lock_i(up_lock), .prot_i(up_prot), .we_i(up_we), .d_i(up_d),
    .q_o(s_q), .ack_o(s_ack), .err_o(s_err), .misaligned_o(s_mis), .stall_o(s_stall),
    .req_o(s_req), .adr_o(s_adr), .size_o(s_size), .lock_o(s_lock), .prot_o(s_prot), .we_o(s_we), .d_o(s_d),
    .q_i(dn_q), .ack_i(dn_ack & ~sel_trap), .err_i(dn_err & ~sel_trap)
  );

  riscv_dmem_misalign #(.XLEN(32), .MODE(MISALIGN_TRAP)) dut_t (
    .clk_i(clk), .rst_ni(rst_n), .req_i(up_req & sel_trap), .adr_i(up_adr), .size_i(up_size),
    .lock_i(up_lock), .prot_i(up_prot), .we_i(up_we), .d_i(up_d),
    .q_o(t_q), .ack_o(t_ack), .err_o(t_err), .misaligned_o(t_mis), .stall_o(t_stall),
    .req_o(t_req), .adr_o(t_adr), .size_o(t_size), .lock_o(t_lock), .prot_o(t_prot), .we_o(t_we), .d_o(t_d),
    .q_i(dn_q), .ack_i(dn_ack & sel_trap), .err_i(dn_err & sel_trap)
  );

  wire [31:0]     dn_adr  = sel_trap ? t_adr  : s_adr;
  wire [31:0]     dn_d    = sel_trap ? t_d    : s_d;
  wire            dn_req  = sel_trap ? t_req  : s_req;
  wire            dn_lock = sel_trap ? t_lock : s_lock;
  wire            dn_we   = sel_trap ? t_we   : s_we;
  wire biu_size_t dn_size = sel_trap ? t_size : s_size;
  wire biu_prot_t dn_prot = sel_trap ? t_prot : s_prot;
  wire [31:0]     rs_q     = sel_trap ? t_q     : s_q;
  wire            rs_ack   = sel_trap ? t_ack   : s_ack;
  wire            rs_err   = sel_trap ? t_err   : s_err;
  wire            rs_mis   = sel_trap ? t_mis   : s_mis;
  wire            rs_stall = sel_trap ? t_stall : s_stall;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Two views of memory: mem is what the downstream responder serves and writes,
  // ref_mem is what the reference model believes memory should hold.
  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction
  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    mem[a]     = b;
    ref_mem[a] = b;
  endtask

  // Transaction context shared by driver, responder and monitor.
  exp_t        exp_q[$];
  logic        resp_seen = 1'b0;
  int          issue_cyc = 0;
  int          dn_count  = 0;
  int          cur_wait  = 0;
  logic        cur_split = 1'b0;
  logic [31:0] cur_base  = '0;
  int          cur_size  = 0;
  logic        cur_we    = 1'b0;
  logic        err_en    = 1'b0;
  logic [31:0] err_adr   = '0;
  int          wcnt      = 0;

  // Downstream memory: answers after cur_wait idle cycles, one response per request.
  always @(negedge clk) begin
    logic hit;
    logic [31:0] wbase;
    dn_ack = 1'b0;
    dn_err = 1'b0;
    if (!rst_n) begin
      wcnt = 0;
    end else if (dn_req) begin
      if (wcnt >= cur_wait) begin
        wcnt = 0;
        if (cur_split) begin
          check("dn_byte_adr", dn_adr, cur_base + 32'(dn_count));
          check("dn_byte_size", 32'(dn_size), 32'(BIU_BYTE));
          check("dn_byte_lock", 32'(dn_lock), 32'd0);
        end else begin
          check("dn_pass_adr", dn_adr, cur_base);
          check("dn_pass_size", 32'(dn_size), 32'(cur_size));
        end
        check("dn_prot", 32'(dn_prot), 32'(up_prot));
        check("dn_we", 32'(dn_we), 32'(cur_we));
        hit = 1'b0;
        for (int k = 0; k < (1 << int'(dn_size)); k++)
          if (err_en && (dn_adr + 32'(k) == err_adr)) hit = 1'b1;
        wbase = {dn_adr[31:2], 2'b00};
        for (int l = 0; l < 4; l++) dn_q[8*l +: 8] = mem_rd(wbase + 32'(l));
        if (hit) begin
          dn_err = 1'b1;
        end else begin
          dn_ack = 1'b1;
          if (dn_we)
            for (int k = 0; k < (1 << int'(dn_size)); k++)
              mem[dn_adr + 32'(k)] = dn_d[8*int'((dn_adr + 32'(k)) & 32'h3) +: 8];
        end
        dn_count++;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: pops the scoreboard whenever the upstream side sees a completion.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (rs_ack || rs_err) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: ack=%0b err=%0b with nothing outstanding", rs_ack, rs_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", 32'(rs_err), 32'(e.err));
          check("resp_ack", 32'(rs_ack), 32'(!e.err));
          check("resp_misaligned", 32'(rs_mis), 32'(e.mis));
          check("resp_latency", 32'(cyc - issue_cyc), 32'(e.lat));
          check("dn_req_count", 32'(dn_count), 32'(e.cnt));
          check("resp_stall", 32'(rs_stall), 32'(e.stall));
          if (e.chk_q) check("resp_q", rs_q & e.qmask, e.q);
        end
        resp_seen = 1'b1;
      end else if (up_req) begin
        check("stall_while_busy", 32'(rs_stall), 32'd1);
      end
    end
  end

  // Driver + reference model: operand byte k lives in lane (adr+k) mod 4; misaligned
  // accesses either trap (one cycle later) or become 2^size byte accesses at adr+k.
  task automatic issue(input logic [31:0] adr, input int size, input logic we, input logic [31:0] op,
                       input logic lock, input logic trap, input int w,
                       input logic een, input logic [31:0] eadr, input logic drop);
    exp_t        e;
    logic [31:0] d;
    logic        mis;
    int          n, e_idx, lane, budget;
    logic        dropping;
    n   = 1 << size;
    mis = (adr & 32'(n - 1)) != 32'd0;
    d   = $urandom;
    for (int k = 0; k < n; k++) begin
      lane = int'((adr + 32'(k)) & 32'h3);
      d[8*lane +: 8] = op[8*k +: 8];
    end
    e.err = 1'b0; e.mis = 1'b0; e.chk_q = 1'b0; e.q = '0; e.qmask = '0;
    e.lat = 0; e.cnt = 0; e.stall = 1'b0;
    e_idx = -1;
    for (int k = 0; k < n; k++)
      if (een && e_idx < 0 && (adr + 32'(k) == eadr)) e_idx = k;
    if (mis && (trap || lock)) begin
      e.err = 1'b1; e.mis = 1'b1; e.lat = 1; e.cnt = 0;
    end else begin
      if (!mis) begin
        e.cnt = 1;
        e.lat = w;
        e.err = (e_idx >= 0);
      end else if (e_idx >= 0) begin
        e.err = 1'b1;
        e.cnt = e_idx + 1;
        e.lat = (e_idx + 1) * (w + 1) + 1;
      end else begin
        e.cnt   = n;
        e.lat   = n * (w + 1) + 1;
        e.stall = 1'b1;
      end
      for (int k = 0; k < n; k++) begin
        lane = int'((adr + 32'(k)) & 32'h3);
        if (we) begin
          // a failed aligned access writes nothing; a failed split keeps the bytes before the error
          if (!e.err || (mis && k < e_idx)) ref_mem[adr + 32'(k)] = op[8*k +: 8];
        end else begin
          e.q[8*lane +: 8]     = ref_rd(adr + 32'(k));
          e.qmask[8*lane +: 8] = 8'hFF;
        end
      end
      e.chk_q = !we && !e.err;
    end
    sel_trap  = trap;
    cur_wait  = w;
    cur_split = mis;
    cur_base  = adr;
    cur_size  = size;
    cur_we    = we;
    err_en    = een;
    err_adr   = eadr;
    dn_count  = 0;
    resp_seen = 1'b0;
    exp_q.push_back(e);
    issue_cyc = cyc;
    up_adr  = adr;
    up_size = biu_size_t'(size);
    up_we   = we;
    up_d    = d;
    up_lock = lock;
    up_prot = biu_prot_t'($urandom_range(0, 7));
    up_req  = 1'b1;
    dropping = drop && mis && !trap && !lock;
    budget   = 200;
    while (!resp_seen && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
      if (dropping) up_req = 1'b0;
    end
    if (!resp_seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_timeout: no response for adr %h size %0d within 200 cycles", adr, size);
      exp_q.delete();
    end
    up_req = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, ea;
    int          sz, w;
    logic        trap, lock, een, drop, we;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_req", 32'(s_req), 32'd0);
    check("rst_s_ack", 32'(s_ack), 32'd0);
    check("rst_s_err", 32'(s_err), 32'd0);
    check("rst_s_mis", 32'(s_mis), 32'd0);
    check("rst_s_stall", 32'(s_stall), 32'd0);
    check("rst_t_err", 32'(t_err), 32'd0);
    check("rst_t_mis", 32'(t_mis), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    poke(32'h100, 8'hEF); poke(32'h101, 8'hBE); poke(32'h102, 8'hAD); poke(32'h103, 8'hDE);
    issue(32'h100, 2, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);

    poke(32'h103, 8'h11); poke(32'h104, 8'h22); poke(32'h105, 8'h33); poke(32'h106, 8'h44);
    issue(32'h103, 2, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);

    issue(32'h0FF, 1, 1'b1, 32'h0000ABCD, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h0FF, 0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h100, 0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);

    issue(32'h101, 2, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 32'h102, 1'b0);
    check("idle_after_split_err", 32'(dut_s.r_state), 32'(ST_IDLE));

    issue(32'h001, 1, 1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h002, 2, 1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    issue(32'hFFFF_FFFE, 2, 1'b0, 32'h0, 1'b0, 1'b0, 1, 1'b0, 32'h0, 1'b0);
    issue(32'h011, 2, 1'b1, 32'h8765_4321, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
    issue(32'h010, 2, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 160; i++) begin
      a    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                         : 32'($urandom_range(0, 63));
      sz   = $urandom_range(0, 2);
      we   = $urandom_range(0, 1) == 1;
      lock = $urandom_range(0, 7) == 0;
      trap = $urandom_range(0, 3) == 0;
      w    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2);
      een  = $urandom_range(0, 5) == 0;
      ea   = a + 32'($urandom_range(0, 3));
      drop = $urandom_range(0, 3) == 0;
      issue(a, sz, we, $urandom, lock, trap, w, een, ea, drop);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset while the second byte of a split load is on the bus.
    sel_trap = 1'b0; cur_wait = 0; cur_split = 1'b1; cur_base = 32'h101; cur_size = 2;
    cur_we = 1'b0; err_en = 1'b0; dn_count = 0;
    up_adr = 32'h101; up_size = BIU_WORD; up_we = 1'b0; up_lock = 1'b0; up_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n  = 1'b0;
    up_req = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", 32'(dut_s.r_state), 32'(ST_IDLE));
    check("midrst_req", 32'(s_req), 32'd0);
    check("midrst_ack", 32'(s_ack), 32'd0);
    check("midrst_err", 32'(s_err), 32'd0);
    check("midrst_mis", 32'(s_mis), 32'd0);
    check("midrst_stall", 32'(s_stall), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_req", 32'(s_req), 32'd0);
    end
    issue(32'h040, 2, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h042, 1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
